ifc_fork: RTL and testbench
===========================

# ifc_fork

Put-to-get fan-out block that is the counterpart of the two-input combining `ifc_` blocks. It accepts one word per cycle on a single put interface (`x`) and broadcasts each accepted word into two independent get interfaces (`a`, `b`). Each get interface has its own FIFO, so the two consumers drain at their own rates. The block uses the same ready/enable method protocol as the rest of the `ifc_` family. It feeds the inputs of those blocks in the test wrappers.

## Interface
Parameters:
- `WIDTH`, 1 — data word width in bits.
- `DEPTH`, 2 — entries per output FIFO; power of two, ≥2.

Ports:
- `CLK`  input  1  — single clock; all state updates on its rising edge.
- `RST_N`  input  1  — reset, asynchronous and active-low.
- `x_en`  input  1  — put enable; enqueue `x_data` this cycle.
- `x_data`  input  WIDTH  — put data.
- `x_rdy`  output  1  — put method ready.
- `a_en`  input  1  — get enable for port a; dequeue the head of FIFO a.
- `a_data`  output  WIDTH  — head of FIFO a.
- `a_rdy`  output  1  — FIFO a non-empty.
- `b_en`, `b_data`, `b_rdy` — same as the port a signals, for FIFO b.

## Operation
- Two identical FIFOs, A and B. Each holds DEPTH entries, with a write pointer, a read pointer and a count in the range 0..DEPTH.
- `x_rdy` = RST_N && (countA < DEPTH) && (countB < DEPTH).
  - A put is accepted only when `x_rdy` is high.
  - The put is all-or-nothing: the word enters both FIFOs in the same cycle, or neither.
- Accepted put (`x_en && x_rdy`): `x_data` is written at wrptrA and wrptrB. Both write pointers increment modulo DEPTH.
- `a_rdy` = (countA != 0). `a_data` = memA[rdptrA] combinationally. The same rules hold for port b.
- Accepted get (`a_en && a_rdy`): rdptrA increments modulo DEPTH.
- Count update per FIFO:
  - +1 on a put only;
  - −1 on a get only;
  - unchanged on a simultaneous put and get, or on neither.
- Enable while not ready (`x_en` with `!x_rdy`, `a_en` with `!a_rdy`) is a protocol violation. The block ignores it: no state change, no error.
- Ordering: each output port delivers words in exactly the order they were accepted on `x`. Every accepted word appears exactly once on `a` and exactly once on `b`.
- Wrap-around: pointers wrap from DEPTH−1 to 0. Full and empty are determined from the count only, never from pointer equality.

## Timing
- Reset (RST_N low, asynchronous assert):
  - counts and pointers go to 0;
  - `x_rdy`=0, `a_rdy`=0, `b_rdy`=0;
  - `a_data` and `b_data` = 0 (memory cleared).
- Reset release is synchronous to CLK. `x_rdy` rises in the first cycle RST_N is high.
- Latency: a word accepted on `x` at edge N is visible on `a_data`/`b_data`, with `a_rdy`/`b_rdy` high, after edge N. There is no same-cycle bypass from `x` to the outputs.
- Full boundary: when either FIFO is full, `x_rdy`=0 even if that FIFO is being dequeued in the same cycle. There is no pipeline-full enqueue. `x_rdy` rises the cycle after the dequeue.
- Empty boundary: a get and a put on the same empty FIFO in one cycle is impossible, because `a_rdy`=0.
- Throughput: one put per cycle sustained while both consumers dequeue every cycle.
- Reset mid-operation: all buffered words are discarded immediately. No partial output is presented after release.

## Test plan
- Reset: hold RST_N=0 with random enables → `x_rdy`=`a_rdy`=`b_rdy`=0 and data=0. Release → `x_rdy`=1, `a_rdy`=`b_rdy`=0.
- Broadcast order (WIDTH=1, DEPTH=2): put 1 then 0, then get both ports → a yields 1, 0 and b yields 1, 0. `a_rdy` first rises the cycle after the first put.
- Backpressure: put 1, 1, no gets → `x_rdy`=0 after the second put. Drain a only → `x_rdy` stays 0 while b is full. One get on b → `x_rdy`=1 on the next cycle.
- Streaming: `a_en`=`b_en`=1 every cycle with a put every cycle of 16 alternating bits → both ports output the same 16 bits in order. `x_rdy` never drops.
- Protocol violation: `x_en`=1 while full, `a_en`=1 while empty → counts and pointers unchanged, and the subsequent data order is intact.
- Reset mid-stream: 1 word buffered in A and 2 in B, then assert RST_N low → `a_rdy`=`b_rdy`=0 immediately. After release, the previously buffered words never appear.

Source files
------------

// File: rtl/ifc_fork_if.sv
// Bundle of the put port (x) and the two get ports (a, b) of ifc_fork.
// Handshake: a method fires on a cycle where its enable and its ready are both high; an enable without ready is ignored.
interface ifc_fork_if #(
   parameter int WIDTH = 1
);
   logic             x_en;
   logic [WIDTH-1:0] x_data;
   logic             x_rdy;
   logic             a_en;
   logic [WIDTH-1:0] a_data;
   logic             a_rdy;
   logic             b_en;
   logic [WIDTH-1:0] b_data;
   logic             b_rdy;

   modport slave (
      input  x_en, x_data, a_en, b_en,
      output x_rdy, a_data, a_rdy, b_data, b_rdy
   );

   modport master (
      output x_en, x_data, a_en, b_en,
      input  x_rdy, a_data, a_rdy, b_data, b_rdy
   );
endinterface

// File: rtl/ifc_fork.sv
// Fan-out of one put stream into two independently drained FIFOs (index 0 feeds port a, index 1 feeds port b).
// A put lands in both FIFOs in the same cycle or in neither.
module ifc_fork #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   ifc_fork_if.slave   io
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem    [2][DEPTH];
   logic [PW-1:0]    wr_ptr [2];
   logic [PW-1:0]    rd_ptr [2];
   logic [CW-1:0]    count  [2];

   logic       put;
   logic       put_rdy;
   logic [1:0] get_en;
   logic [1:0] not_empty;
   logic [1:0] get;

   // Full is judged from the counts alone, so a same-cycle dequeue never opens the put port.
   assign put_rdy   = RST_N && (count[0] < FULL) && (count[1] < FULL);
   assign put       = io.x_en && put_rdy;
   assign get_en    = {io.b_en, io.a_en};
   assign not_empty = {(count[1] != '0), (count[0] != '0)};
   assign get       = get_en & not_empty;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int f = 0; f < 2; f++) begin
            wr_ptr[f] <= '0;
            rd_ptr[f] <= '0;
            count[f]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               mem[f][e] <= '0;
            end
         end
      end else begin
         for (int f = 0; f < 2; f++) begin
            if (put) begin
               mem[f][wr_ptr[f]] <= io.x_data;
               wr_ptr[f]         <= wr_ptr[f] + 1'b1;
            end
            if (get[f]) begin
               rd_ptr[f] <= rd_ptr[f] + 1'b1;
            end
            if (put && !get[f]) begin
               count[f] <= count[f] + 1'b1;
            end else if (!put && get[f]) begin
               count[f] <= count[f] - 1'b1;
            end
         end
      end
   end

   assign io.x_rdy  = put_rdy;
   assign io.a_rdy  = not_empty[0];
   assign io.b_rdy  = not_empty[1];
   assign io.a_data = mem[0][rd_ptr[0]];
   assign io.b_data = mem[1][rd_ptr[1]];

endmodule

// File: tb/tb_ifc_fork.sv
// Bench for ifc_fork (WIDTH=1, DEPTH=2): scenario tasks drive the ports, a negedge monitor
// scores every accepted get against the words accepted on x.
module tb_ifc_fork;
   localparam int W = 1;
   localparam int D = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];

   ifc_fork_if #(.WIDTH(W)) io_if ();

   ifc_fork #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .io    (io_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // Inputs are stable from 1ns after each posedge, so the negedge sees the firing methods.
   always @(negedge clk) begin
      logic [W-1:0] exp;
      if (rst_n) begin
         if (io_if.a_en && io_if.a_rdy) begin
            checks++;
            if (exp_a_q.size() == 0) begin
               errors++;
               $display("FAIL a_extra got %0h expected none", io_if.a_data);
            end else begin
               exp = exp_a_q.pop_front();
               if (io_if.a_data !== exp) begin
                  errors++;
                  $display("FAIL a_data got %0h expected %0h", io_if.a_data, exp);
               end
            end
         end
         if (io_if.b_en && io_if.b_rdy) begin
            checks++;
            if (exp_b_q.size() == 0) begin
               errors++;
               $display("FAIL b_extra got %0h expected none", io_if.b_data);
            end else begin
               exp = exp_b_q.pop_front();
               if (io_if.b_data !== exp) begin
                  errors++;
                  $display("FAIL b_data got %0h expected %0h", io_if.b_data, exp);
               end
            end
         end
         if (io_if.x_en && io_if.x_rdy) begin
            exp_a_q.push_back(io_if.x_data);
            exp_b_q.push_back(io_if.x_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      io_if.x_en   = 1'b0;
      io_if.x_data = '0;
      io_if.a_en   = 1'b0;
      io_if.b_en   = 1'b0;
   endtask

   task automatic check_empty(input string name);
      checks++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || io_if.a_rdy !== 1'b0 || io_if.b_rdy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drained got qa=%0d qb=%0d a_rdy=%b b_rdy=%b expected 0 0 0 0",
                  name, exp_a_q.size(), exp_b_q.size(), io_if.a_rdy, io_if.b_rdy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         io_if.x_en   = 1'($urandom_range(0, 1));
         io_if.x_data = W'($urandom_range(0, 1));
         io_if.a_en   = 1'($urandom_range(0, 1));
         io_if.b_en   = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if ({io_if.x_rdy, io_if.a_rdy, io_if.b_rdy, io_if.a_data, io_if.b_data} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold got x=%b a=%b b=%b ad=%h bd=%h expected all 0",
                     io_if.x_rdy, io_if.a_rdy, io_if.b_rdy, io_if.a_data, io_if.b_data);
         end
         tick();
      end
      idle();
      rst_n = 1'b1;
      #1;
      checks++;
      if ({io_if.x_rdy, io_if.a_rdy, io_if.b_rdy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release got x=%b a=%b b=%b expected 1 0 0",
                  io_if.x_rdy, io_if.a_rdy, io_if.b_rdy);
      end
      tick();
   endtask

   task automatic test_broadcast();
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b1;
      #1;
      checks++;
      if (io_if.a_rdy !== 1'b0) begin
         errors++;
         $display("FAIL bcast_no_bypass got a_rdy=%b expected 0", io_if.a_rdy);
      end
      tick();
      io_if.x_data = 1'b0;
      #1;
      checks++;
      if (io_if.a_rdy !== 1'b1 || io_if.a_data !== 1'b1 || io_if.b_rdy !== 1'b1) begin
         errors++;
         $display("FAIL bcast_latency got a_rdy=%b a_data=%h b_rdy=%b expected 1 1 1",
                  io_if.a_rdy, io_if.a_data, io_if.b_rdy);
      end
      tick();
      idle();
      io_if.a_en = 1'b1;
      io_if.b_en = 1'b1;
      tick();
      tick();
      idle();
      #1;
      check_empty("bcast");
   endtask

   task automatic test_backpressure();
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b1;
      tick();
      tick();
      idle();
      #1;
      checks++;
      if (io_if.x_rdy !== 1'b0) begin
         errors++;
         $display("FAIL bp_full got x_rdy=%b expected 0", io_if.x_rdy);
      end
      io_if.a_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (io_if.x_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_a_drain got x_rdy=%b expected 0", io_if.x_rdy);
         end
         tick();
      end
      idle();
      io_if.b_en = 1'b1;
      #1;
      checks++;
      if (io_if.x_rdy !== 1'b0) begin
         errors++;
         $display("FAIL bp_same_cycle got x_rdy=%b expected 0", io_if.x_rdy);
      end
      tick();
      io_if.b_en = 1'b0;
      #1;
      checks++;
      if (io_if.x_rdy !== 1'b1) begin
         errors++;
         $display("FAIL bp_reopen got x_rdy=%b expected 1", io_if.x_rdy);
      end
      io_if.b_en = 1'b1;
      tick();
      idle();
      #1;
      check_empty("bp");
   endtask

   task automatic test_streaming();
      int drops = 0;
      for (int i = 0; i < 16; i++) begin
         io_if.x_en   = 1'b1;
         io_if.x_data = W'(i % 2);
         io_if.a_en   = 1'b1;
         io_if.b_en   = 1'b1;
         #1;
         if (io_if.x_rdy !== 1'b1) drops++;
         tick();
      end
      io_if.x_en = 1'b0;
      tick();
      idle();
      #1;
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL stream_x_rdy got %0d drops expected 0", drops);
      end
      check_empty("stream");
   endtask

   task automatic test_violation();
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b1;
      tick();
      io_if.x_data = 1'b0;
      tick();
      io_if.x_data = 1'b1;
      tick();
      tick();
      io_if.x_en = 1'b0;
      io_if.a_en = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (io_if.a_rdy !== 1'b0 || io_if.b_rdy !== 1'b1 || io_if.x_rdy !== 1'b0) begin
            errors++;
            $display("FAIL viol_a_empty got a_rdy=%b b_rdy=%b x_rdy=%b expected 0 1 0",
                     io_if.a_rdy, io_if.b_rdy, io_if.x_rdy);
         end
         tick();
      end
      io_if.a_en = 1'b0;
      io_if.b_en = 1'b1;
      tick();
      tick();
      idle();
      #1;
      check_empty("viol");
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b0;
      tick();
      io_if.x_data = 1'b1;
      tick();
      idle();
      io_if.a_en = 1'b1;
      io_if.b_en = 1'b1;
      tick();
      tick();
      idle();
      #1;
      check_empty("viol_after");
   endtask

   task automatic test_reset_mid();
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b1;
      tick();
      io_if.a_en = 1'b1;
      tick();
      idle();
      #1;
      checks++;
      if (io_if.a_rdy !== 1'b1 || io_if.b_rdy !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup got a_rdy=%b b_rdy=%b expected 1 1", io_if.a_rdy, io_if.b_rdy);
      end
      rst_n = 1'b0;
      exp_a_q.delete();
      exp_b_q.delete();
      #1;
      checks++;
      if ({io_if.a_rdy, io_if.b_rdy, io_if.x_rdy, io_if.a_data, io_if.b_data} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset got a=%b b=%b x=%b ad=%h bd=%h expected all 0",
                  io_if.a_rdy, io_if.b_rdy, io_if.x_rdy, io_if.a_data, io_if.b_data);
      end
      tick();
      tick();
      rst_n = 1'b1;
      io_if.a_en = 1'b1;
      io_if.b_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (io_if.a_rdy !== 1'b0 || io_if.b_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale got a_rdy=%b b_rdy=%b expected 0 0", io_if.a_rdy, io_if.b_rdy);
         end
         tick();
      end
      idle();
      io_if.x_en   = 1'b1;
      io_if.x_data = 1'b0;
      tick();
      idle();
      io_if.a_en = 1'b1;
      io_if.b_en = 1'b1;
      tick();
      idle();
      #1;
      check_empty("mid");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      test_reset();
      test_broadcast();
      test_backpressure();
      test_streaming();
      test_violation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
